// File: rtl/button_arbiter_if.sv
// Command-side bundle of the button arbiter: offer handshake, drop pulse
// and the pending-press flags.
interface button_arbiter_if;
    logic       Ready;
    logic       Valid;
    logic [1:0] Code;
    logic       Drop;
    logic [3:0] Pend;

    modport master (input Ready, output Valid, output Code, output Drop, output Pend);
    modport slave  (output Ready, input Valid, input Code, input Drop, input Pend);
endinterface

// File: rtl/button_arbiter.sv
// Four-button press arbiter: synchronise, edge-detect, per-button lockout,
// pending flags and a round-robin valid/ready offer of the pressed button index.
module button_arbiter #(
    parameter int LOCKOUT = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       Bi,
    button_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'b01;
    localparam logic [1:0] ST_OFFER = 2'b10;
    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT);

    logic [3:0] s0_reg, s1_reg, h_reg;
    logic [3:0] pend_reg, pend_next;
    logic [7:0] lock_reg  [4];
    logic [7:0] lock_next [4];
    logic [1:0] ptr_reg, code_reg;
    logic       drop_reg;
    logic [1:0] state_reg, state_next;

    logic [3:0] rise, clear_vec, drop_vec;
    logic [1:0] sel_idx;
    logic       grant;
    logic       valid;

    assign rise  = s1_reg & ~h_reg;
    assign grant = (state_reg == ST_OFFER) && bus.Ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic lock_zero;
            logic accept;
            assign lock_zero = (lock_reg[gi] == 8'd0);
            assign clear_vec[gi] = grant && (code_reg == 2'(gi));
            // A press landing on the same edge as its own grant counts as a fresh press.
            assign accept = rise[gi] && lock_zero && (!pend_reg[gi] || clear_vec[gi]);
            assign drop_vec[gi] = rise[gi] && lock_zero && pend_reg[gi] && !clear_vec[gi];
            assign pend_next[gi] = accept || (pend_reg[gi] && !clear_vec[gi]);
            assign lock_next[gi] = accept    ? LOCK_LOAD :
                                   lock_zero ? 8'd0 : lock_reg[gi] - 8'd1;
        end
    endgenerate

    // Round-robin search starting at ptr_reg; lowest offset wins.
    always_comb begin
        logic [1:0] cand;
        sel_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_reg + 2'(k);
            if (pend_reg[cand]) begin
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s0_reg   <= 4'd0;
            s1_reg   <= 4'd0;
            h_reg    <= 4'd0;
            pend_reg <= 4'd0;
            ptr_reg  <= 2'd0;
            code_reg <= 2'd0;
            drop_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lock_reg[i] <= 8'd0;
            end
        end else begin
            s0_reg   <= Bi;
            s1_reg   <= s0_reg;
            h_reg    <= s1_reg;
            pend_reg <= pend_next;
            drop_reg <= |drop_vec;
            for (int i = 0; i < 4; i++) begin
                lock_reg[i] <= lock_next[i];
            end
            if (state_reg == ST_IDLE && |pend_reg) begin
                code_reg <= sel_idx;
            end
            if (grant) begin
                ptr_reg <= code_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = (|pend_reg) ? ST_OFFER : ST_IDLE;
            ST_OFFER: state_next = bus.Ready ? ST_IDLE : ST_OFFER;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        valid = (state_reg == ST_OFFER);
    end

    assign bus.Valid = valid;
    assign bus.Code  = code_reg;
    assign bus.Drop  = drop_reg;
    assign bus.Pend  = pend_reg;
endmodule
